free_list: RTL and testbench
============================

Name: free_list

Overview:
- Circular FIFO of free physical register indices, directly upstream of the busy table in rename/dispatch.
- Supplies up to two new destination pregs per cycle; these are the same indices dispatch later writes into the busy table as alloc rd.
- Accepts up to two released pregs per cycle from ROB commit (the old prd of each committed instruction).
- Keeps a speculative head and a committed head, so flush rollback is a single pointer copy and ROB walk re-advances the speculative head.

Parameters:
- PREG_NUM, 64, number of physical registers; must be a power of 2.
- ARCH_NUM, 32, architectural registers; pregs 0..ARCH_NUM-1 are mapped at reset, never free initially.
- DEPTH, PREG_NUM-ARCH_NUM (32), FIFO entries; power of 2.
- IDX_W, log2(PREG_NUM) (6), preg index width.

Ports:
- clock in 1: clock
- reset in 1: asynchronous active-high reset
- alloc0_req in 1: dispatch wants a preg for instr0
- alloc1_req in 1: dispatch wants a preg for instr1
- alloc0_prd out IDX_W: preg for instr0
- alloc1_prd out IDX_W: preg for instr1
- alloc_ready out 1: at least 2 speculative entries available
- commit0_valid in 1: commit of an instr that allocated a preg
- commit1_valid in 1: same, second commit slot
- free0_valid in 1: release old prd, slot 0
- free0_prd in IDX_W: preg released, slot 0
- free1_valid in 1: release old prd, slot 1
- free1_prd in IDX_W: preg released, slot 1
- flush_valid in 1: redirect; discard all speculative allocations
- walk0_valid in 1: ROB walk re-allocates one preg
- walk1_valid in 1: ROB walk re-allocates one preg
- spec_count out IDX_W+1: entries between spec head and tail
- dup_err out 1: present only with FREELIST_DUP_CHECK_EN

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Storage: DEPTH x IDX_W array. Three pointers, each log2(DEPTH)+1 bits with a wrap bit: spec_head, cmt_head, tail.
- Reset state:
  - entry i = ARCH_NUM+i.
  - spec_head = cmt_head = 0.
  - tail = DEPTH with wrap bit 1, so the list is full.
  - spec_count = DEPTH; alloc_ready = 1; dup_err = 0.
- Allocation read path (combinational from array and spec_head, zero latency):
  - alloc0_prd = entry[spec_head].
  - alloc1_prd = entry[spec_head+alloc0_req]; instr1 takes the first entry when instr0 does not request.
- Allocation pop, per cycle:
  - Handshake: dispatch must not assert any alloc_req while alloc_ready = 0.
  - Requests are honoured only when alloc_ready = 1, and then spec_head advances by alloc0_req+alloc1_req.
- Walk (flush_valid = 0, no alloc requests):
  - spec_head advances by walk0_valid+walk1_valid.
  - Alloc and walk are mutually exclusive by protocol. If both are seen, walk wins and alloc is ignored.
- Commit: cmt_head advances by commit0_valid+commit1_valid. Commit never passes spec_head; this is guaranteed by the ROB and is not checked.
- Free push:
  - free0 is written at tail; free1 is written at tail+free0_valid.
  - tail advances by the count of valid frees.
  - Frees go only to tail, so they never clobber unconsumed entries.
- Flush:
  - spec_head <= cmt_head after this cycle's commit increment is applied.
  - Allocs and walks in the same cycle are ignored.
  - Frees and commits in the same cycle are still taken.
- Counts:
  - spec_count = tail - spec_head, modulo arithmetic with the wrap bit.
  - alloc_ready = spec_count >= 2, computed from registered pointers.
- Boundaries:
  - Empty (tail == spec_head, wrap bits equal): spec_count = 0, alloc_ready = 0.
  - Full (indices equal, wrap bits differ): count = DEPTH.
  - Pointer wrap past DEPTH-1 returns to index 0 and toggles the wrap bit.
  - Push on full is illegal and cannot occur by construction.
  - Reset mid-operation restores the reset state immediately, regardless of clock.

Optional Feature:
- Macro: FREELIST_DUP_CHECK_EN.
- Defined:
  - A PREG_NUM-bit in_list bitmap; reset value is bits ARCH_NUM..PREG_NUM-1 set.
  - Pop clears the popped bit; push sets the pushed bit.
  - Flush recomputes the bitmap from entries cmt_head..tail-1.
  - Pushing a preg whose bit is already set, or free0_prd == free1_prd with both valid, sets dup_err. dup_err is sticky until reset.
- Undefined: no bitmap, dup_err port absent, zero area.

Test Plan:
- After reset, alloc0_req = alloc1_req = 1 for one cycle -> alloc0_prd = 32, alloc1_prd = 33; next cycle spec_count = 30.
- alloc1_req only (alloc0_req = 0) at reset -> alloc1_prd = 32; spec_head advances by 1.
- 15 cycles of dual alloc, then 1 single alloc -> spec_count = 1, alloc_ready = 0; free0 = 5 and free1 = 7 -> next cycle spec_count = 3, alloc_ready = 1, and 5 sits at index 0 after the tail wraps.
- Alloc 4 (prds 32..35), commit 1, then flush_valid -> spec_head = 1, spec_count = 31, next alloc0_prd = 33.
- After that flush, walk0 = walk1 = 1 for one cycle -> spec_head = 3, next alloc0_prd = 35.
- With FREELIST_DUP_CHECK_EN, free0_prd = 40 while 40 is still in the list -> dup_err = 1 next cycle and stays 1 until reset.

Source files
------------

// File: rtl/free_list_if.sv
// Rename-side free list bus: dispatch alloc, ROB commit/free/walk and flush signals.
// dup_err exists only when FREELIST_DUP_CHECK_EN is defined.
interface free_list_if #(
  parameter int PREG_NUM = 64
) ();
  localparam int IDX_W = $clog2(PREG_NUM);

  logic             alloc0_req;
  logic             alloc1_req;
  logic [IDX_W-1:0] alloc0_prd;
  logic [IDX_W-1:0] alloc1_prd;
  logic             alloc_ready;
  logic             commit0_valid;
  logic             commit1_valid;
  logic             free0_valid;
  logic [IDX_W-1:0] free0_prd;
  logic             free1_valid;
  logic [IDX_W-1:0] free1_prd;
  logic             flush_valid;
  logic             walk0_valid;
  logic             walk1_valid;
  logic [IDX_W:0]   spec_count;
`ifdef FREELIST_DUP_CHECK_EN
  logic             dup_err;
`endif

  modport slave (
    input  alloc0_req, alloc1_req, commit0_valid, commit1_valid,
    input  free0_valid, free0_prd, free1_valid, free1_prd,
    input  flush_valid, walk0_valid, walk1_valid,
`ifdef FREELIST_DUP_CHECK_EN
    output dup_err,
`endif
    output alloc0_prd, alloc1_prd, alloc_ready, spec_count
  );

  modport master (
    output alloc0_req, alloc1_req, commit0_valid, commit1_valid,
    output free0_valid, free0_prd, free1_valid, free1_prd,
    output flush_valid, walk0_valid, walk1_valid,
`ifdef FREELIST_DUP_CHECK_EN
    input  dup_err,
`endif
    input  alloc0_prd, alloc1_prd, alloc_ready, spec_count
  );
endinterface

// File: rtl/free_list.sv
// Circular free-preg FIFO with speculative and committed heads for cheap flush rollback.
// Optional duplicate-free detection is enabled by defining FREELIST_DUP_CHECK_EN.
module free_list #(
  parameter int PREG_NUM = 64,
  parameter int ARCH_NUM = 32,
  parameter int DEPTH    = PREG_NUM - ARCH_NUM
) (
  input  logic       clock,
  input  logic       reset,
  free_list_if.slave bus
);
  localparam int IDX_W = $clog2(PREG_NUM);
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int CW    = IDX_W + 1;

  logic [IDX_W-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]    spec_head_q, spec_head_d;
  logic [PW-1:0]    cmt_head_q, cmt_head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [PW-1:0]    occ;
  logic             alloc_ready;
  logic             walk_any;
  logic             alloc_fire;
  logic [AW-1:0]    spec_idx, spec_idx1;
  logic [AW-1:0]    tail_idx0, tail_idx1;

  assign occ            = tail_q - spec_head_q;
  assign alloc_ready    = occ >= PW'(2);
  assign bus.spec_count = CW'(occ);
  assign bus.alloc_ready = alloc_ready;

  // Walk has priority over alloc; flush overrides both.
  assign walk_any   = bus.walk0_valid | bus.walk1_valid;
  assign alloc_fire = alloc_ready & ~bus.flush_valid & ~walk_any;

  assign spec_idx       = spec_head_q[AW-1:0];
  assign spec_idx1      = spec_idx + AW'(bus.alloc0_req);
  assign bus.alloc0_prd = mem_q[spec_idx];
  assign bus.alloc1_prd = mem_q[spec_idx1];

  assign tail_idx0 = tail_q[AW-1:0];
  assign tail_idx1 = tail_idx0 + AW'(bus.free0_valid);

  always_comb begin
    cmt_head_d  = cmt_head_q + PW'(bus.commit0_valid) + PW'(bus.commit1_valid);
    tail_d      = tail_q + PW'(bus.free0_valid) + PW'(bus.free1_valid);
    spec_head_d = spec_head_q;
    if (bus.flush_valid) begin
      spec_head_d = cmt_head_d;
    end else if (walk_any) begin
      spec_head_d = spec_head_q + PW'(bus.walk0_valid) + PW'(bus.walk1_valid);
    end else if (alloc_fire) begin
      spec_head_d = spec_head_q + PW'(bus.alloc0_req) + PW'(bus.alloc1_req);
    end
  end

  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      mem_d[j] = mem_q[j];
    end
    if (bus.free0_valid) mem_d[tail_idx0] = bus.free0_prd;
    if (bus.free1_valid) mem_d[tail_idx1] = bus.free1_prd;
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clock or posedge reset) begin
      if (reset) mem_q[gi] <= IDX_W'(ARCH_NUM + gi);
      else       mem_q[gi] <= mem_d[gi];
    end
  end

  // Reset tail carries the wrap bit so the list starts full.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      spec_head_q <= '0;
      cmt_head_q  <= '0;
      tail_q      <= PW'(DEPTH);
    end else begin
      spec_head_q <= spec_head_d;
      cmt_head_q  <= cmt_head_d;
      tail_q      <= tail_d;
    end
  end

`ifdef FREELIST_DUP_CHECK_EN
  localparam logic [PREG_NUM-1:0] MAP_RESET = {PREG_NUM{1'b1}} << ARCH_NUM;

  logic [PREG_NUM-1:0] in_list_q, in_list_d;
  logic                dup_q, dup_d;
  logic [PW-1:0]       flush_cnt;
  logic [AW-1:0]       walk_idx1;

  assign flush_cnt = tail_d - cmt_head_d;
  assign walk_idx1 = spec_idx + AW'(bus.walk0_valid);

  always_comb begin
    in_list_d = in_list_q;
    if (bus.flush_valid) begin
      // Rebuild from the surviving committed window, including this cycle's frees.
      in_list_d = '0;
      for (int j = 0; j < DEPTH; j++) begin
        if (PW'(AW'(j) - cmt_head_d[AW-1:0]) < flush_cnt) in_list_d[mem_d[j]] = 1'b1;
      end
    end else begin
      if (walk_any) begin
        if (bus.walk0_valid) in_list_d[mem_q[spec_idx]]  = 1'b0;
        if (bus.walk1_valid) in_list_d[mem_q[walk_idx1]] = 1'b0;
      end else if (alloc_fire) begin
        if (bus.alloc0_req) in_list_d[mem_q[spec_idx]]  = 1'b0;
        if (bus.alloc1_req) in_list_d[mem_q[spec_idx1]] = 1'b0;
      end
      if (bus.free0_valid) in_list_d[bus.free0_prd] = 1'b1;
      if (bus.free1_valid) in_list_d[bus.free1_prd] = 1'b1;
    end
  end

  always_comb begin
    dup_d = dup_q
          | (bus.free0_valid & in_list_q[bus.free0_prd])
          | (bus.free1_valid & in_list_q[bus.free1_prd])
          | (bus.free0_valid & bus.free1_valid & (bus.free0_prd == bus.free1_prd));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_list_q <= MAP_RESET;
      dup_q     <= 1'b0;
    end else begin
      in_list_q <= in_list_d;
      dup_q     <= dup_d;
    end
  end

  assign bus.dup_err = dup_q;
`endif
endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: alloc, wrap, empty, flush, walk and optional dup detection.
module tb_free_list;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  free_list_if #(.PREG_NUM(64)) fl_if ();

  free_list #(.PREG_NUM(64), .ARCH_NUM(32), .DEPTH(32)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (fl_if)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic idle();
    fl_if.alloc0_req    = 1'b0;
    fl_if.alloc1_req    = 1'b0;
    fl_if.commit0_valid = 1'b0;
    fl_if.commit1_valid = 1'b0;
    fl_if.free0_valid   = 1'b0;
    fl_if.free0_prd     = '0;
    fl_if.free1_valid   = 1'b0;
    fl_if.free1_prd     = '0;
    fl_if.flush_valid   = 1'b0;
    fl_if.walk0_valid   = 1'b0;
    fl_if.walk1_valid   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  // Reset is checked before any clock edge to confirm it acts asynchronously.
  task automatic do_reset();
    idle();
    rst = 1'b1;
    #2;
    check("rst_cnt", 32'(fl_if.spec_count), 32);
    check("rst_ready", 32'(fl_if.alloc_ready), 1);
    check("rst_prd0", 32'(fl_if.alloc0_prd), 32);
`ifdef FREELIST_DUP_CHECK_EN
    check("rst_dup", 32'(fl_if.dup_err), 0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    #1;
    do_reset();

    fl_if.alloc0_req = 1'b1; fl_if.alloc1_req = 1'b1; #1;
    check("dual_prd0", 32'(fl_if.alloc0_prd), 32);
    check("dual_prd1", 32'(fl_if.alloc1_prd), 33);
    tick();
    check("dual_cnt", 32'(fl_if.spec_count), 30);
    check("dual_next", 32'(fl_if.alloc0_prd), 34);

    do_reset();
    fl_if.alloc1_req = 1'b1; #1;
    check("a1only_prd1", 32'(fl_if.alloc1_prd), 32);
    tick();
    check("a1only_cnt", 32'(fl_if.spec_count), 31);
    check("a1only_next", 32'(fl_if.alloc0_prd), 33);

    do_reset();
    repeat (15) begin
      fl_if.alloc0_req = 1'b1; fl_if.alloc1_req = 1'b1;
      tick();
    end
    fl_if.alloc0_req = 1'b1;
    tick();
    check("low_cnt", 32'(fl_if.spec_count), 1);
    check("low_ready", 32'(fl_if.alloc_ready), 0);
    check("low_prd0", 32'(fl_if.alloc0_prd), 63);
    fl_if.alloc0_req = 1'b1; fl_if.alloc1_req = 1'b1;
    tick();
    check("noready_hold", 32'(fl_if.spec_count), 1);
    fl_if.free0_valid = 1'b1; fl_if.free0_prd = 6'd5;
    fl_if.free1_valid = 1'b1; fl_if.free1_prd = 6'd7;
    tick();
    check("free_cnt", 32'(fl_if.spec_count), 3);
    check("free_ready", 32'(fl_if.alloc_ready), 1);
    fl_if.alloc0_req = 1'b1;
    tick();
    check("wrap_cnt", 32'(fl_if.spec_count), 2);
    fl_if.alloc0_req = 1'b1; fl_if.alloc1_req = 1'b1; #1;
    check("wrap_prd0", 32'(fl_if.alloc0_prd), 5);
    check("wrap_prd1", 32'(fl_if.alloc1_prd), 7);
    tick();
    check("empty_cnt", 32'(fl_if.spec_count), 0);
    check("empty_ready", 32'(fl_if.alloc_ready), 0);

    do_reset();
    fl_if.alloc0_req = 1'b1; fl_if.alloc1_req = 1'b1;
    tick();
    fl_if.alloc0_req = 1'b1; fl_if.alloc1_req = 1'b1;
    tick();
    check("alloc4_cnt", 32'(fl_if.spec_count), 28);
    fl_if.commit0_valid = 1'b1;
    tick();
    check("commit_cnt", 32'(fl_if.spec_count), 28);
    fl_if.flush_valid = 1'b1; fl_if.alloc0_req = 1'b1; fl_if.alloc1_req = 1'b1;
    tick();
    check("flush_cnt", 32'(fl_if.spec_count), 31);
    check("flush_prd0", 32'(fl_if.alloc0_prd), 33);

    fl_if.walk0_valid = 1'b1; fl_if.walk1_valid = 1'b1; fl_if.alloc0_req = 1'b1;
    tick();
    check("walk_cnt", 32'(fl_if.spec_count), 29);
    check("walk_prd0", 32'(fl_if.alloc0_prd), 35);

    fl_if.flush_valid = 1'b1;
    fl_if.commit0_valid = 1'b1; fl_if.commit1_valid = 1'b1;
    fl_if.free0_valid = 1'b1; fl_if.free0_prd = 6'd2;
    tick();
    check("flushcf_cnt", 32'(fl_if.spec_count), 30);
    check("flushcf_prd0", 32'(fl_if.alloc0_prd), 35);

`ifdef FREELIST_DUP_CHECK_EN
    check("nodup", 32'(fl_if.dup_err), 0);
    fl_if.free0_valid = 1'b1; fl_if.free0_prd = 6'd40;
    tick();
    check("dup_set", 32'(fl_if.dup_err), 1);
    tick();
    check("dup_sticky", 32'(fl_if.dup_err), 1);
    do_reset();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
